// File: rtl/tape_ram_injector.sv
// tape_ram_injector: buffers the cached-tape loader's byte stream in a small
// FIFO and replays it into main RAM during arbiter-granted slots. Once a BASIC
// program has been loaded, the three BASIC end pointers are patched. The end
// of every session is signalled with load_done, plus run_request if autorun
// was seen.
module tape_ram_injector #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] BASIC_START = 16'h0501,
  parameter logic [15:0] PTR_BASE    = 16'h009C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tape_wr,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_dout,
  input  logic        tape_complete,
  input  logic        tape_autorun,
  input  logic        ram_slot,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        tape_hold,
  output logic        fifo_overflow,
  output logic        load_done,
  output logic        run_request,
  output logic [15:0] load_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HOLD_CNT = CW'(FIFO_DEPTH - 2);
  localparam logic [2:0]    LAST_STEP = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_PATCH,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [15:0]   firstAddr_q;
  logic [15:0]   lastAddr_q;
  logic          autorun_q;
  logic          completePrev_q;
  logic [2:0]    patchStep_q;
  logic          ramWe_q;
  logic [15:0]   ramAddr_q;
  logic [7:0]    ramDin_q;
  logic          overflow_q;
  logic          loadDone_q;
  logic          runRequest_q;
  logic [15:0]   loadCount_q;

  logic          fifoEmpty;
  logic          fifoFull;
  logic          acceptState;
  logic          popEn;
  logic          pushEn;
  logic          dropByte;
  logic          completeRise;
  logic          patchEn;
  logic [15:0]   patchPtr;
  logic [15:0]   patchAddr;
  logic [7:0]    patchData;
  logic [23:0]   headEntry;
  logic          autorunSeen;

  // Push/pop qualification, patch value selection and FIFO occupancy update.
  always_comb begin
    fifoEmpty    = (count_q == '0);
    fifoFull     = (count_q == FULL_CNT);
    acceptState  = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_DRAIN);
    popEn        = ram_slot && !fifoEmpty;
    pushEn       = tape_wr && acceptState && (!fifoFull || popEn);
    dropByte     = tape_wr && !pushEn;
    completeRise = tape_complete && !completePrev_q;
    patchEn      = (state_q == S_PATCH) && ram_slot && (patchStep_q != LAST_STEP);
    patchPtr     = lastAddr_q + 16'd1;
    patchAddr    = PTR_BASE + {13'd0, patchStep_q};
    patchData    = patchStep_q[0] ? patchPtr[15:8] : patchPtr[7:0];
    headEntry    = mem_q[rdPtr_q];
    autorunSeen  = autorun_q || tape_autorun;
    count_d      = count_q;
    if (pushEn && !popEn) begin
      count_d = count_q + CW'(1);
    end else if (!pushEn && popEn) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO storage; the read happens in the same cycle, so a push into a full
  // FIFO during a pop never disturbs the entry being read out.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= {tape_addr, tape_dout};
    end
  end

  // Session state machine, FIFO pointers and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      count_q        <= '0;
      firstAddr_q    <= '0;
      lastAddr_q     <= '0;
      autorun_q      <= 1'b0;
      completePrev_q <= 1'b0;
      patchStep_q    <= '0;
      ramWe_q        <= 1'b0;
      ramAddr_q      <= '0;
      ramDin_q       <= '0;
      overflow_q     <= 1'b0;
      loadDone_q     <= 1'b0;
      runRequest_q   <= 1'b0;
      loadCount_q    <= '0;
    end else begin
      ramWe_q        <= 1'b0;
      loadDone_q     <= 1'b0;
      runRequest_q   <= 1'b0;
      completePrev_q <= tape_complete;
      count_q        <= count_d;

      if (pushEn) begin
        wrPtr_q     <= wrPtr_q + AW'(1);
        lastAddr_q  <= tape_addr;
        loadCount_q <= (state_q == S_IDLE) ? 16'd1 : loadCount_q + 16'd1;
      end

      if (popEn) begin
        rdPtr_q   <= rdPtr_q + AW'(1);
        ramWe_q   <= 1'b1;
        ramAddr_q <= headEntry[23:8];
        ramDin_q  <= headEntry[7:0];
      end

      if (dropByte) begin
        overflow_q <= 1'b1;
      end

      if (state_q != S_IDLE && tape_autorun) begin
        autorun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (tape_wr) begin
            state_q     <= S_LOAD;
            firstAddr_q <= tape_addr;
            autorun_q   <= tape_autorun;
            overflow_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (completeRise) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifoEmpty && !tape_wr) begin
            if (firstAddr_q == BASIC_START) begin
              state_q     <= S_PATCH;
              patchStep_q <= '0;
            end else begin
              state_q      <= S_DONE;
              loadDone_q   <= 1'b1;
              runRequest_q <= autorunSeen;
            end
          end
        end
        S_PATCH: begin
          if (patchStep_q == LAST_STEP) begin
            state_q      <= S_DONE;
            loadDone_q   <= 1'b1;
            runRequest_q <= autorunSeen;
          end else if (patchEn) begin
            ramWe_q     <= 1'b1;
            ramAddr_q   <= patchAddr;
            ramDin_q    <= patchData;
            patchStep_q <= patchStep_q + 3'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_we        = ramWe_q;
  assign ram_addr      = ramAddr_q;
  assign ram_din       = ramDin_q;
  assign tape_hold     = (count_q >= HOLD_CNT);
  assign fifo_overflow = overflow_q;
  assign load_done     = loadDone_q;
  assign run_request   = runRequest_q;
  assign load_count    = loadCount_q;

endmodule

// File: tb/tb_tape_ram_injector.sv
// Directed testbench for tape_ram_injector: every expected RAM write is queued
// when stimulus is driven and compared as the DUT emits it.
module tb_tape_ram_injector;

  logic        clk;
  logic        reset;
  logic        tape_wr;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        tape_complete;
  logic        tape_autorun;
  logic        ram_slot;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        tape_hold;
  logic        fifo_overflow;
  logic        load_done;
  logic        run_request;
  logic [15:0] load_count;

  localparam logic [15:0] PTR_BASE = 16'h009C;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int cycle      = 0;

  logic [23:0] expQ[$];
  logic [23:0] expW;
  int writeCount      = 0;
  int sessionWrites   = 0;
  int firstWriteCycle = 0;
  int lastWriteCycle  = 0;
  int doneCount       = 0;
  int doneCycle       = 0;
  int strayRun        = 0;
  logic runAtDone     = 1'b0;

  tape_ram_injector dut (
    .clk          (clk),
    .reset        (reset),
    .tape_wr      (tape_wr),
    .tape_addr    (tape_addr),
    .tape_dout    (tape_dout),
    .tape_complete(tape_complete),
    .tape_autorun (tape_autorun),
    .ram_slot     (ram_slot),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .tape_hold    (tape_hold),
    .fifo_overflow(fifo_overflow),
    .load_done    (load_done),
    .run_request  (run_request),
    .load_count   (load_count)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: compare every RAM write and record load_done timing.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we) begin
        writeCount++;
        sessionWrites++;
        if (sessionWrites == 1) firstWriteCycle = cycle;
        lastWriteCycle = cycle;
        checkOutput("write_expected", 48'(expQ.size() != 0), 48'd1);
        if (expQ.size() != 0) begin
          expW = expQ.pop_front();
          checkOutput("write_addr_data", 48'({ram_addr, ram_din}), 48'(expW));
        end
      end
      if (load_done) begin
        doneCount++;
        doneCycle = cycle;
        runAtDone = run_request;
      end else if (run_request) begin
        strayRun++;
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data,
                               input bit expectWrite);
    @(posedge clk); #1;
    tape_wr   = 1'b1;
    tape_addr = addr;
    tape_dout = data;
    if (expectWrite) expQ.push_back({addr, data});
  endtask

  task automatic endBytes();
    @(posedge clk); #1;
    tape_wr = 1'b0;
  endtask

  task automatic pulseComplete();
    @(posedge clk); #1;
    tape_wr       = 1'b0;
    tape_complete = 1'b1;
    @(posedge clk); #1;
    tape_complete = 1'b0;
  endtask

  task automatic expectPatch(input logic [15:0] p);
    for (int s = 0; s < 6; s++) begin
      expQ.push_back({PTR_BASE + 16'(s), (s % 2 == 1) ? p[15:8] : p[7:0]});
    end
  endtask

  task automatic startSession();
    doneCount     = 0;
    sessionWrites = 0;
    strayRun      = 0;
    runAtDone     = 1'b0;
  endtask

  task automatic waitDone(input int period);
    int k = 0;
    while (doneCount == 0 && k < 300) begin
      @(posedge clk); #1;
      ram_slot = ((k % period) == (period - 1));
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    ram_slot = 1'b0;
    checkOutput("load_done_pulses", 48'(doneCount), 48'd1);
  endtask

  task automatic finishSession(input int expCount, input int expWrites, input bit expRun);
    checkOutput("load_count", 48'(load_count), 48'(expCount));
    checkOutput("session_writes", 48'(sessionWrites), 48'(expWrites));
    checkOutput("done_after_last_write", 48'(doneCycle), 48'(lastWriteCycle + 1));
    checkOutput("run_request", 48'(runAtDone), 48'(expRun));
    checkOutput("stray_run_request", 48'(strayRun), 48'd0);
    checkOutput("queue_drained", 48'(expQ.size()), 48'd0);
  endtask

  initial begin
    int pushCycle;
    int writesBefore;
    reset         = 1'b1;
    tape_wr       = 1'b0;
    tape_addr     = '0;
    tape_dout     = '0;
    tape_complete = 1'b0;
    tape_autorun  = 1'b0;
    ram_slot      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 48'({ram_we, ram_addr, ram_din, tape_hold, fifo_overflow,
                                      load_done, run_request, load_count}), 48'd0);
    reset = 1'b0;

    $display("[TB] BASIC load, slot every cycle");
    startSession();
    ram_slot = 1'b1;
    applyStimulus(16'h0501, 8'hAA, 1'b1);
    pushCycle = cycle;
    applyStimulus(16'h0502, 8'hBB, 1'b1);
    applyStimulus(16'h0503, 8'hCC, 1'b1);
    applyStimulus(16'h0504, 8'hDD, 1'b1);
    expectPatch(16'h0505);
    pulseComplete();
    waitDone(1);
    finishSession(4, 10, 1'b0);
    checkOutput("first_write_latency", 48'(firstWriteCycle), 48'(pushCycle + 2));

    $display("[TB] Autorun");
    startSession();
    ram_slot = 1'b1;
    applyStimulus(16'h0501, 8'hAA, 1'b1);
    applyStimulus(16'h0502, 8'hBB, 1'b1);
    tape_autorun = 1'b1;
    applyStimulus(16'h0503, 8'hCC, 1'b1);
    tape_autorun = 1'b0;
    applyStimulus(16'h0504, 8'hDD, 1'b1);
    expectPatch(16'h0505);
    pulseComplete();
    waitDone(1);
    finishSession(4, 10, 1'b1);

    $display("[TB] Overflow");
    startSession();
    ram_slot = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'h0501 + 16'(i), 8'(8'h10 + i), i < 16);
      if (i == 13) checkOutput("hold_at_13", 48'(tape_hold), 48'd0);
      if (i == 14) checkOutput("hold_at_14", 48'(tape_hold), 48'd1);
      if (i == 16) checkOutput("overflow_at_16", 48'(fifo_overflow), 48'd0);
      if (i == 17) checkOutput("overflow_at_17", 48'(fifo_overflow), 48'd1);
    end
    endBytes();
    checkOutput("overflow_count", 48'(load_count), 48'd16);
    ram_slot = 1'b1;
    expectPatch(16'h0511);
    pulseComplete();
    waitDone(1);
    finishSession(16, 22, 1'b0);
    checkOutput("overflow_sticky", 48'(fifo_overflow), 48'd1);

    $display("[TB] Non-BASIC load, slot every 3rd cycle");
    startSession();
    ram_slot = 1'b0;
    applyStimulus(16'h8000, 8'h11, 1'b1);
    applyStimulus(16'h8001, 8'h22, 1'b1);
    applyStimulus(16'h8002, 8'h33, 1'b1);
    pulseComplete();
    waitDone(3);
    finishSession(3, 3, 1'b0);
    checkOutput("new_session_clears_overflow", 48'(fifo_overflow), 48'd0);

    $display("[TB] Full FIFO, push and pop together");
    startSession();
    ram_slot = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'h0600 + 16'(i), 8'(8'h40 + i), 1'b1);
    end
    applyStimulus(16'h0610, 8'h50, 1'b1);
    ram_slot = 1'b1;
    @(posedge clk); #1;
    tape_wr  = 1'b0;
    ram_slot = 1'b0;
    checkOutput("full_pop_we", 48'(ram_we), 48'd1);
    checkOutput("full_pop_oldest", 48'({ram_addr, ram_din}), 48'h0000_0006_0040);
    checkOutput("full_push_no_overflow", 48'(fifo_overflow), 48'd0);
    checkOutput("full_hold", 48'(tape_hold), 48'd1);
    checkOutput("full_count", 48'(load_count), 48'd17);
    pulseComplete();
    waitDone(1);
    finishSession(17, 17, 1'b0);

    $display("[TB] Reset mid-PATCH");
    startSession();
    ram_slot = 1'b1;
    applyStimulus(16'h0501, 8'h01, 1'b1);
    applyStimulus(16'h0502, 8'h02, 1'b1);
    expectPatch(16'h0503);
    pulseComplete();
    for (int k = 0; k < 100 && sessionWrites < 4; k++) begin
      @(negedge clk); #2;
    end
    checkOutput("writes_before_reset", 48'(sessionWrites), 48'd4);
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_patch_outputs",
                48'({ram_we, ram_addr, ram_din, tape_hold, fifo_overflow,
                     load_done, run_request, load_count}), 48'd0);
    expQ.delete();
    writesBefore = writeCount;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no_write_after_reset", 48'(writeCount), 48'(writesBefore));
    checkOutput("no_done_after_reset", 48'(doneCount), 48'd0);

    $display("[TB] Load after reset");
    startSession();
    applyStimulus(16'h0501, 8'h71, 1'b1);
    applyStimulus(16'h0502, 8'h72, 1'b1);
    applyStimulus(16'h0503, 8'h73, 1'b1);
    expectPatch(16'h0504);
    pulseComplete();
    waitDone(1);
    finishSession(3, 9, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tape_ram_injector.md
# tape_ram_injector

Downstream stage of the cached-tape loader. Accepts the loader's byte-write stream (`tape_addr`/`tape_dout`/`tape_wr`) and buffers it in a small FIFO. Replays the bytes into main RAM only during RAM slots granted by the memory arbiter. After the load completes, it patches the BASIC program-end pointers and raises `load_done` and, when requested, `run_request`.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: entries of {addr[15:0], data[7:0]}; must be a power of 2.
- `BASIC_START`, 16'h0501: first address that marks a BASIC program.
- `PTR_BASE`, 16'h009C: base of the three 16-bit BASIC end pointers.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; one clock domain.
- `tape_wr` in 1: each cycle it is high carries one byte.
- `tape_addr` in 16: target address of that byte.
- `tape_dout` in 8: byte value.
- `tape_complete` in 1: loader finished; the rising edge is significant.
- `tape_autorun` in 1: autorun request; any high cycle during a session counts.
- `ram_slot` in 1: arbiter grant; the RAM is free in the following cycle.
- `ram_we` out 1: write strobe, one cycle per write.
- `ram_addr` out 16: write address.
- `ram_din` out 8: write data.
- `tape_hold` out 1: FIFO count ≥ FIFO_DEPTH-2; advisory for upstream.
- `fifo_overflow` out 1: sticky; a byte was dropped.
- `load_done` out 1: one-cycle pulse at the end of a session.
- `run_request` out 1: one-cycle pulse, coincident with `load_done`, only when autorun was latched.
- `load_count` out 16: bytes accepted this session; wraps modulo 2^16.

## Operation
Reset value of every output is 0. FIFO, state and latches are cleared.

States:
- **IDLE**
  - `tape_wr`=1 → LOAD. That byte is pushed.
  - `first_addr` is captured from it.
  - `autorun_l`, `load_count` and `fifo_overflow` are cleared the same cycle.
- **LOAD**
  - Push every `tape_wr` cycle. Pop on `ram_slot`.
  - `last_addr` ← `tape_addr` of each accepted byte.
  - `tape_autorun`=1 sets `autorun_l`.
  - Rising edge of `tape_complete` → DRAIN.
- **DRAIN**
  - Pushes are still accepted. Pops continue on `ram_slot`.
  - FIFO empty, with no push this cycle:
    - → PATCH if `first_addr`==BASIC_START;
    - → DONE otherwise.
- **PATCH**
  - P = `last_addr`+1, 16-bit wrap (FFFF→0000).
  - Six writes, one per `ram_slot`:
    - PTR_BASE+0 = P[7:0], +1 = P[15:8]
    - +2 = P[7:0], +3 = P[15:8]
    - +4 = P[7:0], +5 = P[15:8]
  - After the sixth write → DONE.
  - `tape_wr` here is dropped and sets `fifo_overflow`.
- **DONE**
  - `load_done`=1 and `run_request`=`autorun_l` for one cycle.
  - → IDLE.

Rules:
- FIFO push when full and no pop: byte dropped, `fifo_overflow`←1, `load_count` not incremented.
- Full with simultaneous push and pop: both occur, count unchanged, no overflow.
- Pop from empty FIFO: no write, `ram_we` stays 0.
- Writes leave in strict FIFO order, then the patch writes. No write is ever repeated.
- `tape_autorun` is ignored in IDLE unless it coincides with the first `tape_wr`.
- Reset at any point aborts the session immediately. Partially issued patch sequences are not resumed.

## Timing
- `ram_slot` high in cycle N with data pending (FIFO entry or patch step) → `ram_we`=1 in cycle N+1 for exactly one cycle.
- `ram_addr`/`ram_din` are registered and valid in N+1; they hold their last value otherwise.
- Back-to-back slots give back-to-back writes.
- Push in cycle N is eligible for a pop from cycle N+1. Minimum byte-to-RAM latency: slot at N+1, write at N+2.
- `tape_complete` edge detect uses a one-cycle-delayed copy. A byte accepted in the same cycle as the edge is included.
- DONE follows the final `ram_we` cycle by one cycle. `load_done` is high in the cycle after the last write.
- `tape_hold` is combinational from the FIFO count.

## Test plan
- **BASIC load, slot every cycle.** Bytes 0x0501–0x0504 = AA,BB,CC,DD, then `tape_complete`.
  - Expect 4 ordered writes at 1-cycle latency.
  - Then 6 patch writes: 009C=05, 009D=05, 009E=05, 009F=05, 00A0=05, 00A1=05.
  - Then `load_done` pulse, `run_request`=0, `load_count`=4.
- **Autorun.** Same load with a one-cycle `tape_autorun` during LOAD.
  - Expect `run_request` and `load_done` high in the same single cycle.
- **Overflow.** 20 bytes from 0x0501 with `ram_slot`=0; then slots every cycle.
  - `tape_hold` rises at count 14.
  - `fifo_overflow`=1 from the 17th byte.
  - Exactly 16 writes, 0x0501–0x0510, then patch with P=0x0511; `load_count`=16.
- **Non-BASIC load.** 3 bytes at 0x8000, slot every 3rd cycle.
  - Expect 3 writes only, no PTR_BASE writes, `load_done` one cycle after the third write.
- **Full FIFO, push and pop together.** At full, assert `tape_wr` and `ram_slot` together.
  - Expect no overflow, count unchanged, the oldest entry written next cycle.
- **Reset mid-PATCH.** Assert `reset` after the second patch write.
  - Expect all outputs 0 immediately and no further `ram_we`.
  - A new load afterwards runs normally.
